// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants, FSM state type and slice helper for the
//               main-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_def_num_req = 4;
    localparam int unsigned c_def_addr_w  = 11;
    localparam int unsigned c_def_data_w  = 32;
    localparam int unsigned c_def_rd_lat  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Low bit of requester idx's field inside a flattened per-requester bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first set request bit
//               searching upward from last_owner+1 with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = c_def_num_req
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_owner,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx
);

    localparam int unsigned c_idx_w = $clog2(NUM_REQ);

    logic [c_idx_w-1:0] w_cand;
    logic               w_found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_idx_w'((int'(last_owner) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                winner[w_cand] = 1'b1;
                winner_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Session-based round-robin arbiter for the single-port main
//               memory, with read-data ownership tagging.
//               Optional macro ARB_HOLD_LIMIT_EN caps a session at MAX_HOLD
//               granted cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = c_def_num_req,
    parameter int unsigned ADDR_W  = c_def_addr_w,
    parameter int unsigned DATA_W  = c_def_data_w,
    parameter int unsigned RD_LAT  = c_def_rd_lat
`ifdef ARB_HOLD_LIMIT_EN
    ,
    parameter int unsigned MAX_HOLD = 2048
`endif
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_we,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int unsigned c_idx_w = $clog2(NUM_REQ);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt, w_pick;
    logic [c_idx_w-1:0] r_owner, w_owner_nxt, r_last_owner, w_last_nxt, w_pick_idx;
    logic [1:0]         r_drain, w_drain_nxt;
    logic [ADDR_W-1:0]  r_addr_hold;
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] r_pipe      [RD_LAT];
    logic [NUM_REQ-1:0] w_tag;
    logic               w_own_req, w_own_we, w_mem_we, w_hold_hit, w_leave;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_addr_arr[i]  = req_addr[slice_lo(i, ADDR_W) +: ADDR_W];
            assign w_wdata_arr[i] = req_wdata[slice_lo(i, DATA_W) +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .winner     (w_pick),
        .winner_idx (w_pick_idx)
    );

    assign w_own_req = req[r_owner];
    assign w_own_we  = req_we[r_owner];
    // A write presented in the cycle req drops must not reach the RAM.
    assign w_mem_we  = (r_state == GRANT) && w_own_req && w_own_we && !reset;
    assign w_leave   = (r_state == GRANT) && (!w_own_req || w_hold_hit);

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned c_hold_w = $clog2(MAX_HOLD);

    logic [c_hold_w-1:0] r_hold;

    always_ff @(posedge CLOCK_50) begin
        if (reset || r_state != GRANT || w_leave)
            r_hold <= '0;
        else
            r_hold <= r_hold + c_hold_w'(1);
    end

    assign w_hold_hit = (r_hold == c_hold_w'(MAX_HOLD - 1));
`else
    assign w_hold_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_drain_nxt = r_drain;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick;
                    w_owner_nxt = w_pick_idx;
                end
            end
            GRANT: begin
                if (w_leave) begin
                    w_state_nxt = DRAIN;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_owner;
                    w_drain_nxt = 2'(RD_LAT - 1);
                end
            end
            DRAIN: begin
                if (r_drain == 2'd0)
                    w_state_nxt = IDLE;
                else
                    w_drain_nxt = r_drain - 2'd1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= c_idx_w'(NUM_REQ - 1);
            r_drain      <= '0;
            r_addr_hold  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_drain      <= w_drain_nxt;
            if (r_state == GRANT)
                r_addr_hold <= w_addr_arr[r_owner];
        end
    end

    // Only genuine reads of the current owner are tagged for read-back.
    assign w_tag = (r_state == GRANT && w_own_req && !w_mem_we) ? r_grant : '0;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_tag;
            for (int i = 1; i < RD_LAT; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign grant     = r_grant;
    assign rd_valid  = r_pipe[RD_LAT-1];
    assign rd_data   = mem_rdata;
    assign mem_addr  = (r_state == GRANT) ? w_addr_arr[r_owner] : r_addr_hold;
    assign mem_wdata = (r_state == GRANT) ? w_wdata_arr[r_owner] : '0;
    assign mem_we    = w_mem_we;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               behavioural 2048x32 RAM (RD_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_n   = 4;
    localparam int c_aw  = 11;
    localparam int c_dw  = 32;
    localparam int c_lat = 1;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic [c_n-1:0]       req;
    logic [c_n*c_aw-1:0]  req_addr;
    logic [c_n*c_dw-1:0]  req_wdata;
    logic [c_n-1:0]       req_we;
    logic [c_n-1:0]       grant;
    logic [c_n-1:0]       rd_valid;
    logic [c_dw-1:0]      rd_data;
    logic [c_aw-1:0]      mem_addr;
    logic [c_dw-1:0]      mem_wdata;
    logic                 mem_we;
    logic [c_dw-1:0]      mem_rdata;
    logic                 busy;

    always #5 CLOCK_50 = ~CLOCK_50;

    mem_port_arbiter #(
        .NUM_REQ   (c_n),
        .ADDR_W    (c_aw),
        .DATA_W    (c_dw),
        .RD_LAT    (c_lat)
`ifdef ARB_HOLD_LIMIT_EN
        ,
        .MAX_HOLD  (8)
`endif
    ) u_dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .grant     (grant),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Unwritten locations read back a fixed address-derived pattern.
    logic [31:0]   r_mem [2048];
    logic [2047:0] r_seen = '0;

    function automatic logic [31:0] pat(input logic [10:0] a);
        return 32'hA5A5_0000 | {21'd0, a};
    endfunction

    always @(posedge CLOCK_50) begin
        if (mem_we) begin
            r_mem[mem_addr]  <= mem_wdata;
            r_seen[mem_addr] <= 1'b1;
        end
        mem_rdata <= r_seen[mem_addr] ? r_mem[mem_addr] : pat(mem_addr);
    end

    function automatic logic [31:0] mem_peek(input logic [10:0] a);
        return r_seen[a] ? r_mem[a] : pat(a);
    endfunction

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic set_slot(input int idx, input logic we, input logic [10:0] addr,
                            input logic [31:0] data);
        req_we[idx[1:0]]                 = we;
        req_addr[idx*c_aw +: c_aw]       = addr;
        req_wdata[idx*c_dw +: c_dw]      = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [3:0] exp_seq [5];
    int         waited;
    int         cnt;

    initial begin
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) tick();
        chk("rst_grant",    64'(grant),     64'h0);
        chk("rst_busy",     64'(busy),      64'h0);
        chk("rst_rd_valid", 64'(rd_valid),  64'h0);
        chk("rst_mem_we",   64'(mem_we),    64'h0);
        chk("rst_mem_addr", 64'(mem_addr),  64'h0);
        chk("rst_mem_wdata",64'(mem_wdata), 64'h0);
        reset = 1'b0;

        // Single write session by requester 0
        set_slot(0, 1'b1, 11'h005, 32'hDEADBEEF);
        req = 4'b0001;
        #1;
        chk("arb_latency_grant", 64'(grant), 64'h0);
        tick();
        chk("w0_grant",     64'(grant),     64'b0001);
        chk("w0_busy",      64'(busy),      64'h1);
        chk("w0_mem_we",    64'(mem_we),    64'h1);
        chk("w0_mem_addr",  64'(mem_addr),  64'h005);
        chk("w0_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        tick();
        req = '0; req_we = '0;
        tick();
        chk("drain_grant",     64'(grant),    64'h0);
        chk("drain_busy",      64'(busy),     64'h1);
        chk("drain_mem_we",    64'(mem_we),   64'h0);
        chk("drain_addr_hold", 64'(mem_addr), 64'h005);
        chk("w0_mem_content",  64'(mem_peek(11'h005)), 64'hDEADBEEF);
        tick();
        chk("idle_after_drain", 64'(busy), 64'h0);

        // Requester 2 reads 0x7FF, then writes 0x010
        set_slot(2, 1'b0, 11'h7FF, 32'h0);
        req = 4'b0100;
        tick();
        chk("r2_grant",    64'(grant),    64'b0100);
        chk("r2_mem_we",   64'(mem_we),   64'h0);
        chk("r2_mem_addr", 64'(mem_addr), 64'h7FF);
        chk("r2_rdv_addr_cycle", 64'(rd_valid), 64'h0);
        tick();
        chk("r2_rd_valid", 64'(rd_valid), 64'b0100);
        chk("r2_rd_data",  64'(rd_data),  64'hA5A507FF);
        set_slot(2, 1'b1, 11'h010, 32'hCAFEF00D);
        #1;
        chk("r2_write_we", 64'(mem_we), 64'h1);
        tick();
        chk("r2_no_rdv_on_write", 64'(rd_valid), 64'h0);
        req = '0; req_we = '0;
        tick();
        chk("r2_mem_content", 64'(mem_peek(11'h010)), 64'hCAFEF00D);
        tick();

        // Requester 1 drops req while presenting a write
        set_slot(1, 1'b0, 11'h020, 32'h0);
        req = 4'b0010;
        tick();
        chk("d1_grant", 64'(grant), 64'b0010);
        req = '0;
        set_slot(1, 1'b1, 11'h020, 32'h55AA55AA);
        #1;
        chk("d1_drop_we", 64'(mem_we), 64'h0);
        tick();
        chk("d1_mem_unchanged", 64'(mem_peek(11'h020)), 64'hA5A50020);
        chk("d1_no_rdv",        64'(rd_valid),          64'h0);
        req_we = '0;
        tick();

        // Reset during a write session of requester 3
        set_slot(3, 1'b1, 11'h030, 32'h0BADCAFE);
        req = 4'b1000;
        tick();
        chk("rs_grant",  64'(grant),  64'b1000);
        chk("rs_mem_we", 64'(mem_we), 64'h1);
        reset = 1'b1;
        #1;
        chk("rs_reset_cycle_we", 64'(mem_we), 64'h0);
        tick();
        chk("rs_grant_after",    64'(grant),    64'h0);
        chk("rs_busy_after",     64'(busy),     64'h0);
        chk("rs_rdv_after",      64'(rd_valid), 64'h0);
        chk("rs_write_lost",     64'(mem_peek(11'h030)), 64'hA5A50030);
        reset = 1'b0; req = '0; req_we = '0;
        tick();

        // All four requesting: strict round-robin with RD_LAT+1 gaps
        for (int i = 0; i < c_n; i++)
            set_slot(i, 1'b0, 11'(i * 16), 32'h0);
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            waited = 0;
            while (grant == 4'b0 && waited < 10) begin
                tick();
                waited++;
            end
            chk($sformatf("rr_grant_%0d", s), 64'(grant), 64'(exp_seq[s]));
            if (s > 0)
                chk($sformatf("rr_gap_%0d", s), 64'(waited), 64'd2);
            req = req & ~grant;
            tick();
            req = (s == 4) ? 4'b0001 : 4'b1111;
        end

        // Lone requester re-requesting
        waited = 0;
        while (grant == 4'b0 && waited < 10) begin
            tick();
            waited++;
        end
        chk("rereq_grant", 64'(grant),  64'b0001);
        chk("rereq_gap",   64'(waited), 64'd2);
        req = '0;
        repeat (3) tick();

`ifdef ARB_HOLD_LIMIT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0011;
        for (int s = 0; s < 3; s++) begin
            waited = 0;
            while (grant == 4'b0 && waited < 10) begin
                tick();
                waited++;
            end
            chk($sformatf("hold_grant_%0d", s), 64'(grant),
                64'((s == 1) ? 4'b0010 : 4'b0001));
            if (s > 0)
                chk($sformatf("hold_gap_%0d", s), 64'(waited), 64'd2);
            if (s < 2) begin
                cnt = 0;
                while (grant != 4'b0 && cnt < 20) begin
                    cnt++;
                    tick();
                end
                chk($sformatf("hold_len_%0d", s), 64'(cnt), 64'd8);
            end
        end
        req = '0;
        repeat (3) tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
